// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: direction codes, grid constants and
// the reversal test used by both the body controller and the navigation FSM.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

   localparam int GRID_H_CELLS      = 160;
   localparam int GRID_V_CELLS      = 120;
   localparam int GRID_X_W          = 8;
   localparam int GRID_Y_W          = 7;
   localparam int SNAKE_MAX_LEN     = 32;
   localparam int SNAKE_INIT_LEN    = 4;
   localparam int SNAKE_TICK_PERIOD = 5000000;

   // Opposite directions share the axis bit and differ only in the sign bit.
   function automatic logic is_reverse(input dir_t a, input dir_t b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Free-running move-tick counter; TICK is high during the terminal count,
// so the edge that wraps the counter is the move edge.
module snake_tick_gen #(
   parameter int TICK_PERIOD = 5000000
) (
   input  logic CLK,
   input  logic RESET,
   input  logic ENABLE,
   output logic TICK
);

   localparam int CW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_PERIOD - 1);

   logic [CW-1:0] count;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   // ENABLE only masks the pulse; the counter keeps running regardless.
   assign TICK = ENABLE && (count == LAST);

endmodule

// File: rtl/snake_body_control.sv
// Snake body: segment shift register with wrap-around head movement, growth,
// sticky self-collision and a registered per-cell occupancy query.
module snake_body_control
   import snake_pkg::*;
#(
   parameter int H_CELLS     = GRID_H_CELLS,
   parameter int V_CELLS     = GRID_V_CELLS,
   parameter int X_W         = GRID_X_W,
   parameter int Y_W         = GRID_Y_W,
   parameter int MAX_LEN     = SNAKE_MAX_LEN,
   parameter int INIT_LEN    = SNAKE_INIT_LEN,
   parameter int TICK_PERIOD = SNAKE_TICK_PERIOD
) (
   input  logic           CLK,
   input  logic           RESET,
   input  logic [1:0]     DIRECTION,
   input  logic           EAT,
   input  logic [X_W-1:0] ADDRH,
   input  logic [Y_W-1:0] ADDRV,
   output logic [X_W-1:0] HEAD_X,
   output logic [Y_W-1:0] HEAD_Y,
   output logic [5:0]     LENGTH,
   output logic           MOVE_STROBE,
   output logic           SNAKE_HIT,
   output logic           HEAD_HIT,
   output logic           SELF_COLLIDE
);

   logic [X_W-1:0] seg_x [MAX_LEN];
   logic [Y_W-1:0] seg_y [MAX_LEN];
   dir_t           applied_dir;
   dir_t           dir_in;
   dir_t           next_dir;
   logic [5:0]     length;
   logic [5:0]     new_len;
   logic           grow_pending;
   logic           move_strobe;
   logic           snake_hit;
   logic           head_hit;
   logic           self_collide;
   logic           tick;
   logic           move_enable;
   logic           collide_now;
   logic           query_snake;
   logic           query_head;
   logic [X_W-1:0] next_x;
   logic [Y_W-1:0] next_y;

   assign move_enable = ~self_collide;
   assign dir_in      = dir_t'(DIRECTION);

   snake_tick_gen #(
      .TICK_PERIOD(TICK_PERIOD)
   ) u_tick (
      .CLK   (CLK),
      .RESET (RESET),
      .ENABLE(move_enable),
      .TICK  (tick)
   );

   always_comb begin
      next_dir = applied_dir;
      if (!is_reverse(dir_in, applied_dir)) begin
         next_dir = dir_in;
      end
      next_x = seg_x[0];
      next_y = seg_y[0];
      case (next_dir)
         DIR_UP:    next_y = (seg_y[0] == '0) ? Y_W'(V_CELLS - 1) : seg_y[0] - Y_W'(1);
         DIR_DOWN:  next_y = (seg_y[0] == Y_W'(V_CELLS - 1)) ? '0 : seg_y[0] + Y_W'(1);
         DIR_LEFT:  next_x = (seg_x[0] == '0) ? X_W'(H_CELLS - 1) : seg_x[0] - X_W'(1);
         default:   next_x = (seg_x[0] == X_W'(H_CELLS - 1)) ? '0 : seg_x[0] + X_W'(1);
      endcase
   end

   // Collision looks at the post-move body: new seg[i] is old seg[i-1].
   always_comb begin
      new_len = length;
      if ((grow_pending || EAT) && (length < 6'(MAX_LEN))) begin
         new_len = length + 6'd1;
      end
      collide_now = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         if ((6'(i) < new_len) && (next_x == seg_x[i-1]) && (next_y == seg_y[i-1])) begin
            collide_now = 1'b1;
         end
      end
   end

   always_comb begin
      query_snake = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if ((6'(i) < length) && (seg_x[i] == ADDRH) && (seg_y[i] == ADDRV)) begin
            query_snake = 1'b1;
         end
      end
      query_head = (seg_x[0] == ADDRH) && (seg_y[0] == ADDRV);
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= X_W'(H_CELLS / 2);
            seg_y[i] <= Y_W'(V_CELLS / 2 + i);
         end
         applied_dir  <= DIR_UP;
         length       <= 6'(INIT_LEN);
         grow_pending <= 1'b0;
         move_strobe  <= 1'b0;
         snake_hit    <= 1'b0;
         head_hit     <= 1'b0;
         self_collide <= 1'b0;
      end else begin
         move_strobe <= 1'b0;
         snake_hit   <= query_snake;
         head_hit    <= query_head;
         if (tick) begin
            for (int i = 1; i < MAX_LEN; i++) begin
               seg_x[i] <= seg_x[i-1];
               seg_y[i] <= seg_y[i-1];
            end
            seg_x[0]     <= next_x;
            seg_y[0]     <= next_y;
            applied_dir  <= next_dir;
            length       <= new_len;
            grow_pending <= 1'b0;
            move_strobe  <= 1'b1;
            if (collide_now) begin
               self_collide <= 1'b1;
            end
         end else if (EAT && !self_collide) begin
            grow_pending <= 1'b1;
         end
      end
   end

   assign HEAD_X       = seg_x[0];
   assign HEAD_Y       = seg_y[0];
   assign LENGTH       = length;
   assign MOVE_STROBE  = move_strobe;
   assign SNAKE_HIT    = snake_hit;
   assign HEAD_HIT     = head_hit;
   assign SELF_COLLIDE = self_collide;

endmodule

// File: doc/snake_body_control.md
Name: snake_body_control

Overview:
- Consumer of the 2-bit DIRECTION code produced by the navigation FSM.
- Owns the snake's position on a cell grid: generates the game move tick, advances the head with wrap-around, shifts the body, grows on EAT and detects self-collision.
- Answers registered per-cell "is snake here" queries for the VGA colour path.

Parameters:
- H_CELLS, 160, grid width in cells
- V_CELLS, 120, grid height in cells
- X_W, 8, x coordinate width (2^X_W >= H_CELLS)
- Y_W, 7, y coordinate width (2^Y_W >= V_CELLS)
- MAX_LEN, 32, segment register count and maximum length
- INIT_LEN, 4, length after reset (2..MAX_LEN)
- TICK_PERIOD, 5000000, CLK cycles per move

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-low reset (0 = reset)
- DIRECTION  in  2  00 up, 01 down, 10 left, 11 right
- EAT  in  1  one-cycle pulse: head reached target, grow by one
- ADDRH  in  X_W  query cell x
- ADDRV  in  Y_W  query cell y
- HEAD_X  out  X_W  current head x
- HEAD_Y  out  Y_W  current head y
- LENGTH  out  6  current length (sized for MAX_LEN = 32)
- MOVE_STROBE  out  1  one-cycle pulse, the cycle after each move
- SNAKE_HIT  out  1  query cell holds an active segment
- HEAD_HIT  out  1  query cell is the head
- SELF_COLLIDE  out  1  sticky game-over flag

Behaviour:
- Reset (RESET = 0 at a CLK edge), overrides everything including a move in progress:
  - seg[i] = (H_CELLS/2, V_CELLS/2 + i) for all i; LENGTH = INIT_LEN.
  - Applied direction = up; tick counter = 0; grow_pending = 0.
  - MOVE_STROBE, SNAKE_HIT, HEAD_HIT, SELF_COLLIDE = 0.
- Tick:
  - Counter runs 0..TICK_PERIOD-1. On the edge where it equals TICK_PERIOD-1 it returns to 0 and a move occurs.
  - MOVE_STROBE is high for exactly the following cycle.
  - Counter keeps running after collision, but moves are suppressed and the strobe stays 0.
- Direction sampling: DIRECTION is sampled only on the move edge.
  - A reversal (up<->down, left<->right) relative to the applied direction is ignored; the applied direction is kept.
  - Otherwise the sampled code becomes the applied direction.
- Move, all in one edge:
  - seg[i] <= seg[i-1] for i = 1..MAX_LEN-1; seg[0] <= head + delta.
  - Up: y-1. Down: y+1. Left: x-1. Right: x+1.
- Wrap-around:
  - x = 0 moving left -> H_CELLS-1; x = H_CELLS-1 moving right -> 0.
  - y = 0 moving up -> V_CELLS-1; y = V_CELLS-1 moving down -> 0.
  - No out-of-range coordinate ever appears.
- Grow:
  - EAT sets grow_pending. EAT on the move edge itself counts for that move.
  - On a move with pending set: LENGTH += 1 if LENGTH < MAX_LEN, else LENGTH holds (saturates). Pending is cleared either way.
  - Multiple EAT pulses between moves collapse to one grow.
- Self-collision:
  - Evaluated on the new head against new seg[1..LENGTH_new-1].
  - A match sets SELF_COLLIDE on the same edge as the move (visible together with MOVE_STROBE).
  - SELF_COLLIDE stays set until reset. Positions freeze; EAT is ignored.
- Query:
  - SNAKE_HIT = 1 if any seg[i] with i < LENGTH equals (ADDRH, ADDRV); HEAD_HIT = 1 if seg[0] matches.
  - Both are registered: 1-cycle latency from address to output.
  - Query on a move edge compares against pre-move positions.
- HEAD_X/HEAD_Y are seg[0] directly, with no extra register.
- Segments at index >= LENGTH still shift but are never reported or compared.

Decomposition:
- Shared package snake_pkg:
  - Direction codes DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b11.
  - Function is_reverse(a, b).
  - Grid constants. These are also used by the navigation FSM and the VGA wrapper.
- One sub-module, snake_tick_gen (parameter TICK_PERIOD; ports CLK, RESET, ENABLE, TICK): a counter with a 1-cycle terminal pulse.
- Segment array, collision and query logic stay in snake_body_control.

Test Plan (bench uses TICK_PERIOD = 4, defaults otherwise):
- Reset, hold DIRECTION = 00 -> HEAD = (80,60), LENGTH = 4, outputs 0. First MOVE_STROBE in the 5th cycle after reset release, HEAD = (80,59).
- DIRECTION = 00 for 60 moves from y = 60 -> y reaches 0, next move gives y = 119 (wrap). Similarly x = 159 moving right -> 0.
- Applied up, DIRECTION = 01 at a move edge -> still moves up. Then 11 -> x+1; then 10 -> ignored, x+1 again.
- EAT pulse mid-period -> LENGTH 4 -> 5 at the next move. EAT on the move edge -> grows that move. Grow to 32, then EAT -> stays 32.
- Length 5 at (80,60) heading up; moves right, down, left -> head (80,61) = seg4. SELF_COLLIDE = 1 with that strobe; HEAD frozen afterwards.
- ADDRH/ADDRV = (80,62) after reset -> SNAKE_HIT = 1, HEAD_HIT = 0 one cycle later. (80,60) -> both 1. (80,64) with LENGTH = 4 -> 0.
- Assert RESET mid-period after collision -> all reset values restored on that edge.
